// File: rtl/serial_lane_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : serial_lane_arbiter_if
// Brief  : Requester handshakes and serial lane outputs of the lane arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_lane_arbiter_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  ser_first;
  logic                  ser_owner;
  logic                  busy;
  logic                  done;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output ser_out, ser_valid, ser_first, ser_owner, busy, done
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  ser_out, ser_valid, ser_first, ser_owner, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_lane_arbiter.sv
//------------------------------------------------------------------------------
// Module : serial_lane_arbiter
// Brief  : Two-requester round-robin arbiter serialising one word per frame.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_lane_arbiter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_lane_arbiter_if.slave     bus
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    owner_q;
  logic                    last_owner_q;
  logic                    ser_out_q;
  logic                    ser_valid_q;
  logic                    ser_first_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    idle;
  logic                    grant0;
  logic                    grant1;

  // Reset masks the grant so a handshake can never complete in a reset cycle.
  assign idle   = (state_q == ST_IDLE) && !rst;
  assign grant0 = idle && bus.req0_valid && (!bus.req1_valid || last_owner_q);
  assign grant1 = idle && bus.req1_valid && (!bus.req0_valid || !last_owner_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_first_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            shreg_q     <= grant1 ? bus.req1_data : bus.req0_data;
            owner_q     <= grant1;
            cnt_q       <= '0;
            state_q     <= ST_SHIFT;
            ser_out_q   <= grant1 ? bus.req1_data[0] : bus.req0_data[0];
            ser_valid_q <= 1'b1;
            ser_first_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          shreg_q     <= shreg_q >> 1;
          cnt_q       <= cnt_q + 1'b1;
          ser_first_q <= 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_GAP;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            // Output is registered, so preload the bit the next cycle will show.
            ser_out_q <= shreg_q[1];
          end
        end
        ST_GAP: begin
          state_q      <= ST_IDLE;
          last_owner_q <= owner_q;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_first_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_first  = ser_first_q;
  assign bus.ser_owner  = owner_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: doc/serial_lane_arbiter.md
SERIAL_LANE_ARBITER -- requirements
Module: serial_lane_arbiter

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 4, bits per serial frame (>= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has a word to send.
REQ-005 SHALL have port: req0_data  input  DATA_WIDTH  requester 0 word.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 SHALL have ports: req1_valid / req1_data / req1_ready, same as requester 0.
REQ-008 SHALL have port: ser_out  output  1  serial data bit, LSB first.
REQ-009 SHALL have port: ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-010 SHALL have port: ser_first  output  1  high with bit 0 of each frame.
REQ-011 SHALL have port: ser_owner  output  1  index of the requester owning the current frame.
REQ-012 SHALL have port: busy  output  1  high in SHIFT and GAP.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, GAP; reset state IDLE.
REQ-015 Grant in IDLE SHALL be: only one valid -> that one; both valid -> requester != last_owner.
REQ-016 reqN_ready SHALL be combinational: state==IDLE and granted N; never high outside IDLE; at most one ready high per cycle.
REQ-017 On valid&&ready, the block SHALL capture reqN_data into a DATA_WIDTH shift register, set owner=N, clear bit counter, and enter SHIFT next cycle.
REQ-018 In SHIFT, each cycle SHALL drive ser_out=shreg[0] and ser_valid=1, shift right by one, and increment the counter.
REQ-019 ser_first SHALL be high only on the first SHIFT cycle of each frame.
REQ-020 After DATA_WIDTH SHIFT cycles, the FSM SHALL enter GAP for exactly one cycle with done=1, set last_owner=owner, then return to IDLE.
REQ-021 Frame timing SHALL be: accept cycle T; bits on T+1..T+DATA_WIDTH; done on T+DATA_WIDTH+1; earliest next accept T+DATA_WIDTH+2.
REQ-022 Outside SHIFT, ser_out, ser_valid and ser_first SHALL be 0; ser_owner SHALL hold the last owner.
REQ-023 Input data SHALL be sampled only at the handshake; valid held without ready SHALL not be dropped and SHALL be granted at the next IDLE per REQ-015.
REQ-024 A requester deasserting valid before being granted SHALL not be served.
REQ-025 The counter SHALL be sized ceil(log2(DATA_WIDTH+1)) and never wrap inside a frame.

Reset
REQ-026 With rst=1 at a clock edge, the next cycle SHALL have state=IDLE, shreg=0, counter=0, owner=0, last_owner=1 (requester 0 favoured), and all outputs 0.
REQ-027 Reset mid-frame (SHIFT or GAP) SHALL abandon the frame: no further bits, no done pulse, ready per REQ-016 from the first post-reset cycle.
REQ-028 rst SHALL take priority over any handshake in the same cycle.

Verification (DATA_WIDTH=4)
REQ-029 Single frame: after reset, req0_valid=1 with req0_data=4'b1011 at cycle 0 -> req0_ready=1 at cycle 0; ser_out=1,1,0,1 on cycles 1-4 with ser_valid=1; ser_first at cycle 1 only; done at cycle 5; busy on cycles 1-5.
REQ-030 Contention: both valid from reset, req0=4'hA, req1=4'h5 held -> req0 served first (bits 0,1,0,1, ser_owner=0), then req1 accepted at cycle 6 (bits 1,0,1,0, ser_owner=1), then req0 again.
REQ-031 Back-to-back single requester: req1_valid held high with 4'hF -> accepts every 6 cycles; ser_valid gap of exactly 2 cycles between frames.
REQ-032 Late request: req1_valid rises during a req0 frame -> req1_ready stays 0 until IDLE, then req1 is granted at the first IDLE cycle.
REQ-033 Reset mid-shift: rst=1 on the cycle after the 2nd bit -> next cycle ser_valid=0, busy=0, no done, and both valid -> req0 granted.
